// File: rtl/screen_pkg.sv
// Shared definitions for the game-flow controller and the VGA drawer mux.
//
// Contents:
//   screen_t       - drawer mux select, also used as the flow-controller state
//   SECONDS_W      - width of the HUD seconds counter
//   LEDS_W         - width of the debug LED bus
//   screen_onehot  - one-hot decode of a screen_t, used for the debug LEDs
package screen_pkg;

   typedef enum logic [1:0] {
      SCR_START = 2'd0,
      SCR_PLAY  = 2'd1,
      SCR_WIN   = 2'd2,
      SCR_LOSE  = 2'd3
   } screen_t;

   localparam int SECONDS_W = 10;
   localparam int LEDS_W    = 10;

   function automatic logic [3:0] screen_onehot(input screen_t s);
      logic [3:0] oh;
      case (s)
         SCR_START: oh = 4'b0001;
         SCR_PLAY:  oh = 4'b0010;
         SCR_WIN:   oh = 4'b0100;
         default:   oh = 4'b1000;
      endcase
      return oh;
   endfunction

endpackage

// File: rtl/button_edge_sync.sv
// Two-flop synchronizer followed by a registered rising-edge detector for a
// raw, asynchronous, active-high button or switch.
//
// Ports:
//   clk     in  1  destination clock
//   srst    in  1  synchronous active-high reset
//   button  in  1  raw button level (asynchronous to clk)
//   rise    out 1  one-cycle pulse, high on the third clk edge after the raw
//                  rising edge is first sampled
module button_edge_sync (
   input  logic clk,
   input  logic srst,
   input  logic button,
   output logic rise
);

   logic sync1_reg;
   logic sync2_reg;
   logic prev_reg;
   logic rise_reg;

   always_ff @(posedge clk) begin
      if (srst) begin
         sync1_reg <= 1'b0;
         sync2_reg <= 1'b0;
         prev_reg  <= 1'b0;
         rise_reg  <= 1'b0;
      end else begin
         sync1_reg <= button;
         sync2_reg <= sync1_reg;
         prev_reg  <= sync2_reg;
         // Registered so downstream logic sees a clean, glitch-free pulse.
         rise_reg  <= sync2_reg & ~prev_reg;
      end
   end

   assign rise = rise_reg;

endmodule

// File: rtl/screen_sequencer.sv
// Game-flow controller: decides which screen drawer owns the shared VGA
// background/sprite path (START -> PLAY -> WIN/LOSE -> START), drives the
// level reset and counts whole seconds of play for the HUD. State only
// changes on cycles where frame_start is high, so a frame never tears.
//
// Ports:
//   vga_clock    in  1   single clock
//   reset        in  1   synchronous active-high reset
//   frame_start  in  1   one-cycle pulse at start of vertical blanking
//   jump_button  in  1   raw active-high button (asynchronous)
//   win          in  1   level reports goal reached (only honoured in PLAY)
//   lose         in  1   level reports death/timeout (only honoured in PLAY)
//   screen_sel   out 2   drawer mux select (screen_t encoding)
//   level_reset  out 1   high whenever the screen is not PLAY
//   level_start  out 1   one-cycle pulse on the cycle PLAY is entered
//   seconds      out 10  whole seconds spent in the current/last play
//   leds         out 10  [3:0] one-hot state, [4] start_req, [9:5] zero
module screen_sequencer
   import screen_pkg::*;
#(
   parameter int FRAMES_PER_SEC = 60,
   parameter int HOLD_FRAMES    = 180,
   parameter int MAX_SECONDS    = 999
) (
   input  logic                 vga_clock,
   input  logic                 reset,
   input  logic                 frame_start,
   input  logic                 jump_button,
   input  logic                 win,
   input  logic                 lose,
   output logic [1:0]           screen_sel,
   output logic                 level_reset,
   output logic                 level_start,
   output logic [SECONDS_W-1:0] seconds,
   output logic [LEDS_W-1:0]    leds
);

   localparam int HOLD_W  = $clog2(HOLD_FRAMES + 1);
   localparam int FRAME_W = $clog2(FRAMES_PER_SEC + 1);

   localparam logic [HOLD_W-1:0]    HOLD_LAST  = HOLD_W'(HOLD_FRAMES - 1);
   localparam logic [FRAME_W-1:0]   FRAME_LAST = FRAME_W'(FRAMES_PER_SEC - 1);
   localparam logic [SECONDS_W-1:0] SEC_MAX    = SECONDS_W'(MAX_SECONDS);

   logic jump_rise;

   screen_t              state_reg,       state_next;
   logic                 start_req_reg,   start_req_next;
   logic [HOLD_W-1:0]    hold_cnt_reg,    hold_cnt_next;
   logic [FRAME_W-1:0]   frame_cnt_reg,   frame_cnt_next;
   logic [SECONDS_W-1:0] seconds_reg,     seconds_next;
   logic                 level_reset_reg, level_reset_next;
   logic                 level_start_reg, level_start_next;
   logic [3:0]           onehot_reg,      onehot_next;

   button_edge_sync u_jump_sync (
      .clk    (vga_clock),
      .srst   (reset),
      .button (jump_button),
      .rise   (jump_rise)
   );

   always_comb begin
      state_next     = state_reg;
      start_req_next = start_req_reg;
      hold_cnt_next  = hold_cnt_reg;
      frame_cnt_next = frame_cnt_reg;
      seconds_next   = seconds_reg;

      case (state_reg)
         SCR_START: begin
            start_req_next = start_req_reg | jump_rise;
            // A rise landing on the frame_start cycle starts play on that
            // same frame rather than waiting for the next one.
            if (frame_start && (start_req_reg || jump_rise)) begin
               state_next     = SCR_PLAY;
               start_req_next = 1'b0;
               frame_cnt_next = '0;
               seconds_next   = '0;
            end
         end

         SCR_PLAY: begin
            start_req_next = 1'b0;
            if (frame_start) begin
               if (frame_cnt_reg == FRAME_LAST) begin
                  frame_cnt_next = '0;
                  if (seconds_reg < SEC_MAX) begin
                     seconds_next = seconds_reg + 1'b1;
                  end
               end else begin
                  frame_cnt_next = frame_cnt_reg + 1'b1;
               end

               // lose wins the tie so a simultaneous death never shows WIN.
               if (lose) begin
                  state_next    = SCR_LOSE;
                  hold_cnt_next = '0;
               end else if (win) begin
                  state_next    = SCR_WIN;
                  hold_cnt_next = '0;
               end
            end
         end

         default: begin // SCR_WIN, SCR_LOSE: counters frozen for display
            start_req_next = 1'b0;
            if (frame_start) begin
               if (hold_cnt_reg == HOLD_LAST) begin
                  state_next    = SCR_START;
                  hold_cnt_next = '0;
               end else begin
                  hold_cnt_next = hold_cnt_reg + 1'b1;
               end
            end
         end
      endcase

      // Outputs are registered from the next state so they move with it.
      level_reset_next = (state_next != SCR_PLAY);
      level_start_next = (state_reg != SCR_PLAY) && (state_next == SCR_PLAY);
      onehot_next      = screen_onehot(state_next);
   end

   always_ff @(posedge vga_clock) begin
      if (reset) begin
         state_reg       <= SCR_START;
         start_req_reg   <= 1'b0;
         hold_cnt_reg    <= '0;
         frame_cnt_reg   <= '0;
         seconds_reg     <= '0;
         level_reset_reg <= 1'b1;
         level_start_reg <= 1'b0;
         onehot_reg      <= 4'b0001;
      end else begin
         state_reg       <= state_next;
         start_req_reg   <= start_req_next;
         hold_cnt_reg    <= hold_cnt_next;
         frame_cnt_reg   <= frame_cnt_next;
         seconds_reg     <= seconds_next;
         level_reset_reg <= level_reset_next;
         level_start_reg <= level_start_next;
         onehot_reg      <= onehot_next;
      end
   end

   assign screen_sel  = state_reg;
   assign level_reset = level_reset_reg;
   assign level_start = level_start_reg;
   assign seconds     = seconds_reg;
   assign leds        = {5'b00000, start_req_reg, onehot_reg};

endmodule

// File: tb/tb_screen_sequencer.sv
module tb_screen_sequencer;

   logic       vga_clock = 1'b0;
   logic       reset = 1'b1;
   logic       frame_start = 1'b0;
   logic       jump_button = 1'b0;
   logic       win = 1'b0;
   logic       lose = 1'b0;
   logic [1:0] screen_sel;
   logic       level_reset;
   logic       level_start;
   logic [9:0] seconds;
   logic [9:0] leds;

   int tests_run = 0;
   int tests_failed = 0;

   // MAX_SECONDS is lowered so saturation is reachable in a short run.
   screen_sequencer #(
      .FRAMES_PER_SEC (60),
      .HOLD_FRAMES    (180),
      .MAX_SECONDS    (9)
   ) dut (
      .vga_clock   (vga_clock),
      .reset       (reset),
      .frame_start (frame_start),
      .jump_button (jump_button),
      .win         (win),
      .lose        (lose),
      .screen_sel  (screen_sel),
      .level_reset (level_reset),
      .level_start (level_start),
      .seconds     (seconds),
      .leds        (leds)
   );

   always #5 vga_clock = ~vga_clock;

   // One frame_start pulse, then idle cycles; returns at a falling edge.
   task automatic frames(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge vga_clock) frame_start = 1'b1;
         @(negedge vga_clock) frame_start = 1'b0;
         repeat (2) @(negedge vga_clock);
      end
   endtask

   task automatic press_jump();
      @(negedge vga_clock) jump_button = 1'b1;
      repeat (6) @(negedge vga_clock);
      jump_button = 1'b0;
      repeat (6) @(negedge vga_clock);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge vga_clock);
      reset = 1'b0;
      @(negedge vga_clock);
      tests_run++;
      if (screen_sel !== 2'd0) begin tests_failed++; $display("FAIL reset_sel got %0d want 0", screen_sel); end
      tests_run++;
      if (level_reset !== 1'b1 || level_start !== 1'b0) begin tests_failed++; $display("FAIL reset_lvl got rst=%b start=%b want 1/0", level_reset, level_start); end
      tests_run++;
      if (seconds !== 10'd0) begin tests_failed++; $display("FAIL reset_seconds got %0d want 0", seconds); end
      tests_run++;
      if (leds !== 10'h001) begin tests_failed++; $display("FAIL reset_leds got %h want 001", leds); end
      $display("[TB] reset: sel=%0d lvl_rst=%b sec=%0d leds=%h", screen_sel, level_reset, seconds, leds);

      // Five idle frames, with win/lose waved about: START must hold.
      win = 1'b1; lose = 1'b1;
      frames(5);
      win = 1'b0; lose = 1'b0;
      tests_run++;
      if (screen_sel !== 2'd0 || leds !== 10'h001) begin tests_failed++; $display("FAIL idle_frames got sel=%0d leds=%h want 0/001", screen_sel, leds); end
      $display("[TB] idle frames: sel=%0d leds=%h", screen_sel, leds);
   endtask

   task automatic test_start();
      press_jump();
      tests_run++;
      if (leds !== 10'h011) begin tests_failed++; $display("FAIL start_req got leds=%h want 011", leds); end
      // No frame_start: state must not move however long we wait.
      repeat (20) @(negedge vga_clock);
      tests_run++;
      if (screen_sel !== 2'd0) begin tests_failed++; $display("FAIL no_frame_hold got sel=%0d want 0", screen_sel); end
      @(negedge vga_clock) frame_start = 1'b1;
      @(negedge vga_clock) frame_start = 1'b0;
      tests_run++;
      if (screen_sel !== 2'd1 || level_start !== 1'b1 || level_reset !== 1'b0) begin
         tests_failed++;
         $display("FAIL enter_play got sel=%0d start=%b rst=%b want 1/1/0", screen_sel, level_start, level_reset);
      end
      tests_run++;
      if (leds !== 10'h002) begin tests_failed++; $display("FAIL play_leds got %h want 002", leds); end
      @(negedge vga_clock);
      tests_run++;
      if (level_start !== 1'b0) begin tests_failed++; $display("FAIL level_start_width got %b want 0", level_start); end
      $display("[TB] start: sel=%0d lvl_rst=%b leds=%h", screen_sel, level_reset, leds);
   endtask

   task automatic test_seconds();
      frames(125);
      tests_run++;
      if (seconds !== 10'd2) begin tests_failed++; $display("FAIL seconds_125 got %0d want 2", seconds); end
      $display("[TB] 125 frames: seconds=%0d", seconds);
      // 125 + 600 frames is well past 9 * 60: must saturate at 9.
      frames(600);
      tests_run++;
      if (seconds !== 10'd9) begin tests_failed++; $display("FAIL seconds_sat got %0d want 9", seconds); end
      // Press in PLAY must not be queued.
      press_jump();
      tests_run++;
      if (leds !== 10'h002) begin tests_failed++; $display("FAIL play_press_dropped got leds=%h want 002", leds); end
      $display("[TB] saturate: seconds=%0d", seconds);
   endtask

   task automatic test_both();
      win = 1'b1; lose = 1'b1;
      frames(1);
      win = 1'b0; lose = 1'b0;
      tests_run++;
      if (screen_sel !== 2'd3 || level_reset !== 1'b1 || leds !== 10'h008) begin
         tests_failed++;
         $display("FAIL lose_priority got sel=%0d rst=%b leds=%h want 3/1/008", screen_sel, level_reset, leds);
      end
      frames(179);
      tests_run++;
      if (screen_sel !== 2'd3) begin tests_failed++; $display("FAIL hold_179 got sel=%0d want 3", screen_sel); end
      frames(1);
      tests_run++;
      if (screen_sel !== 2'd0 || leds !== 10'h001) begin tests_failed++; $display("FAIL hold_180 got sel=%0d leds=%h want 0/001", screen_sel, leds); end
      tests_run++;
      if (seconds !== 10'd9) begin tests_failed++; $display("FAIL lose_seconds_held got %0d want 9", seconds); end
      $display("[TB] lose hold: sel=%0d seconds=%0d", screen_sel, seconds);
   endtask

   task automatic test_coincident();
      // Raw edge before edge 1 -> rise high between edges 3 and 4;
      // frame_start is driven in that same window.
      @(negedge vga_clock) jump_button = 1'b1;
      repeat (3) @(negedge vga_clock);
      frame_start = 1'b1;
      @(negedge vga_clock) frame_start = 1'b0;
      tests_run++;
      if (screen_sel !== 2'd1 || level_start !== 1'b1) begin
         tests_failed++;
         $display("FAIL coincident got sel=%0d start=%b want 1/1", screen_sel, level_start);
      end
      tests_run++;
      if (seconds !== 10'd0) begin tests_failed++; $display("FAIL seconds_clear got %0d want 0", seconds); end
      repeat (4) @(negedge vga_clock);
      jump_button = 1'b0;
      repeat (4) @(negedge vga_clock);
      $display("[TB] coincident: sel=%0d seconds=%0d", screen_sel, seconds);
   endtask

   task automatic test_win();
      frames(61);                     // seconds=1, frame_cnt=1
      win = 1'b1;
      frames(1);                      // counted in PLAY, frame_cnt=2
      win = 1'b0;
      tests_run++;
      if (screen_sel !== 2'd2 || leds !== 10'h004) begin tests_failed++; $display("FAIL enter_win got sel=%0d leds=%h want 2/004", screen_sel, leds); end
      tests_run++;
      if (seconds !== 10'd1) begin tests_failed++; $display("FAIL win_seconds got %0d want 1", seconds); end
      press_jump();
      tests_run++;
      if (leds !== 10'h004) begin tests_failed++; $display("FAIL win_press_dropped got leds=%h want 004", leds); end
      frames(180);
      tests_run++;
      if (screen_sel !== 2'd0 || leds !== 10'h001) begin tests_failed++; $display("FAIL win_return got sel=%0d leds=%h want 0/001", screen_sel, leds); end
      frames(3);
      tests_run++;
      if (screen_sel !== 2'd0 || seconds !== 10'd1) begin tests_failed++; $display("FAIL start_wait got sel=%0d sec=%0d want 0/1", screen_sel, seconds); end
      $display("[TB] win: sel=%0d seconds=%0d", screen_sel, seconds);
   endtask

   task automatic test_reset_in_play();
      press_jump();
      frames(1);
      tests_run++;
      if (screen_sel !== 2'd1) begin tests_failed++; $display("FAIL replay got sel=%0d want 1", screen_sel); end
      frames(420);
      tests_run++;
      if (seconds !== 10'd7) begin tests_failed++; $display("FAIL seconds_7 got %0d want 7", seconds); end
      @(negedge vga_clock) reset = 1'b1;
      @(negedge vga_clock) reset = 1'b0;
      tests_run++;
      if (screen_sel !== 2'd0 || seconds !== 10'd0 || level_reset !== 1'b1 || level_start !== 1'b0 || leds !== 10'h001) begin
         tests_failed++;
         $display("FAIL mid_play_reset got sel=%0d sec=%0d rst=%b start=%b leds=%h want 0/0/1/0/001",
                  screen_sel, seconds, level_reset, level_start, leds);
      end
      @(negedge vga_clock);
      tests_run++;
      if (level_start !== 1'b0 || screen_sel !== 2'd0) begin tests_failed++; $display("FAIL post_reset got start=%b sel=%0d want 0/0", level_start, screen_sel); end
      $display("[TB] reset in play: sel=%0d seconds=%0d", screen_sel, seconds);
   endtask

   initial begin
      test_reset();
      test_start();
      test_seconds();
      test_both();
      test_coincident();
      test_win();
      test_reset_in_play();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
